// File: rtl/qspis_reg2wb.sv
// ---------------------------------------------------------------------------
// qspis_reg2wb
//
// Back end of the QSPI slave interface. Takes the single-outstanding reg_*
// request handshake and runs exactly one classic Wishbone master cycle per
// request. It returns read data and a one-cycle completion pulse, and it keeps
// a sticky bus-error flag for debug.
//
// Optional feature: define QSPIS_WB_TMO_EN to add a bus timeout. A cycle that
// is still unanswered after 2**TMO_W-1 BUS cycles is then abandoned. Without
// the macro, BUS waits for the slave indefinitely.
//
// Ports
//   sys_clk, rst_n            clock, asynchronous active-low reset
//   reg_wr / reg_rd           level requests, held until reg_ack
//   reg_addr/reg_be/reg_wdata request address, byte enables, write data
//   reg_rdata / reg_ack       read data (held), one-cycle completion pulse
//   wbm_*                     Wishbone classic master port
//   bus_err / err_clr         sticky error flag and its synchronous clear
// ---------------------------------------------------------------------------
module qspis_reg2wb #(
    parameter logic [7:0]  WB_ADR_HI = 8'h00,
    parameter int          TMO_W     = 8,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [23:0] reg_addr,
    input  logic [3:0]  reg_be,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        bus_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {IDLE, BUS, ACK, WDONE} state_e;

    state_e      state_q, state_d;
    logic [23:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        err_set;
    logic        tmo_hit;
    logic        req;

    assign req = reg_wr | reg_rd;

`ifdef QSPIS_WB_TMO_EN
    // The timeout fires on the BUS cycle whose increment would bring the
    // counter to its all-ones value. A cycle therefore times out after
    // 2**TMO_W-1 BUS cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - 1'b1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == IDLE && req) begin
            tmo_d = '0;
        end else if (state_q == BUS && !wbm_ack_i && !wbm_err_i) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end

    // A slave answer in the same cycle takes precedence over the timeout.
    assign tmo_hit = (state_q == BUS) && (tmo_q == TMO_LAST) && !wbm_ack_i && !wbm_err_i;
`else
    assign tmo_hit = 1'b0;
`endif

    // State and datapath registers.
    // NOTE: Sequential state uses non-blocking assignments. That way every
    // register samples its pre-edge value, whatever order the blocks run in.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state logic.
    // NOTE: Every output of a combinational block gets a default first.
    // Otherwise an unassigned path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = BUS;
            BUS:     if (wbm_err_i || wbm_ack_i || tmo_hit) state_d = ACK;
            ACK:     state_d = WDONE;
            WDONE:   if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture the request, then capture the response.
    always_comb begin
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_set = 1'b0;
        if (state_q == IDLE && req) begin
            adr_d = reg_addr;
            sel_d = reg_be;
            dat_d = reg_wdata;
            // A simultaneous read and write request resolves to the write and is flagged.
            we_d    = reg_wr;
            err_set = reg_wr & reg_rd;
        end else if (state_q == BUS) begin
            if (wbm_err_i) begin
                rdata_d = ERR_RDATA;
                err_set = 1'b1;
            end else if (wbm_ack_i) begin
                if (!we_q) rdata_d = wbm_dat_i;
            end else if (tmo_hit) begin
                rdata_d = ERR_RDATA;
                err_set = 1'b1;
            end
        end
        // If a new error and err_clr arrive in the same cycle, the error wins.
        bus_err_d = err_set | (bus_err_q & ~err_clr);
    end

    // Outputs are decoded from the state. Reset therefore drops cyc/stb at
    // once and no reg_ack can follow.
    always_comb begin
        wbm_cyc_o = (state_q == BUS);
        wbm_stb_o = (state_q == BUS);
        reg_ack   = (state_q == ACK);
    end

    assign wbm_adr_o = {WB_ADR_HI, adr_q};
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = dat_q;
    assign wbm_we_o  = we_q;
    assign reg_rdata = rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_qspis_reg2wb.sv
// ---------------------------------------------------------------------------
// tb_qspis_reg2wb
//
// Self-checking bench for qspis_reg2wb. A behavioural Wishbone slave answers
// with a programmable number of wait states, with an error, or not at all.
// Each request pushes its expected reg_rdata into a scoreboard queue. A monitor
// pops and compares that entry on every reg_ack.
// The timeout scenario is built only when QSPIS_WB_TMO_EN is defined.
// ---------------------------------------------------------------------------
module tb_qspis_reg2wb;

    localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_wr, reg_rd;
    logic [23:0] reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        bus_err;
    logic        err_clr;

    always #5 clk = ~clk;

    qspis_reg2wb #(
        .WB_ADR_HI (8'h00),
        .TMO_W     (4),
        .ERR_RDATA (ERR_RD)
    ) dut (
        .sys_clk   (clk),
        .rst_n     (rst_n),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_be    (reg_be),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .bus_err   (bus_err),
        .err_clr   (err_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- Wishbone slave model ----------------
    int          sl_waits = 0;
    int          sl_mode  = 0;        // 0 ack, 1 err, 2 silent
    logic [31:0] sl_dat   = '0;
    int          sl_cnt   = 0;

    always @(negedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
            if (sl_mode != 2 && sl_cnt >= sl_waits) begin
                if (sl_mode == 1) wbm_err_i = 1'b1;
                else begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = sl_dat;
                end
            end else begin
                sl_cnt++;
            end
        end else begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            sl_cnt    = 0;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] sb_q[$];
    int          ack_count = 0;
    int          wb_count  = 0;
    logic        cyc_prev  = 1'b0;

    always @(negedge clk) begin
        if (reg_ack) begin
            ack_count++;
            if (sb_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
            else                  check("rdata", reg_rdata, sb_q.pop_front());
        end
        if (wbm_cyc_o || wbm_stb_o) check("cyc_eq_stb", {31'd0, wbm_stb_o}, {31'd0, wbm_cyc_o});
        if (wbm_cyc_o && !cyc_prev) wb_count++;
        cyc_prev = wbm_cyc_o;
    end

    // ---------------- request driver ----------------
    logic [31:0] last_rdata  = '0;
    logic        exp_bus_err = 1'b0;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;

    task automatic do_req(input logic wr, input logic rd, input logic [23:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input int waits, input int mode, input logic [31:0] sdat,
                          input int hold, output int lat, output int cyc_n);
        logic [31:0] exp;
        bit          done;
        sl_waits = waits;
        sl_mode  = mode;
        sl_dat   = sdat;
        if (mode != 0) exp = ERR_RD;
        else if (wr)   exp = last_rdata;
        else           exp = sdat;
        last_rdata = exp;
        sb_q.push_back(exp);
        if (mode != 0 || (wr && rd)) exp_bus_err = 1'b1;
        reg_wr = wr; reg_rd = rd; reg_addr = addr; reg_be = be; reg_wdata = wdata;
        lat = 0; cyc_n = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (wbm_cyc_o) begin
                if (cyc_n == 0) begin
                    cap_adr = wbm_adr_o; cap_dat = wbm_dat_o;
                    cap_sel = wbm_sel_o; cap_we  = wbm_we_o;
                end
                cyc_n++;
            end
            if (reg_ack) done = 1;
        end
        if (!done) check("ack_timeout", 32'd0, 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("held_no_cyc", {31'd0, wbm_cyc_o}, 32'd0);
            check("held_no_ack", {31'd0, reg_ack}, 32'd0);
        end
        reg_wr = 1'b0;
        reg_rd = 1'b0;
        // ACK->WDONE, then WDONE->IDLE once the request has dropped.
        repeat (2) @(negedge clk);
        check("bus_err_after", {31'd0, bus_err}, {31'd0, exp_bus_err});
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_bus_err = 1'b0;
        check("err_clr", {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int lat, cyc_n, wb0, ack0;
        rst_n = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0;
        reg_be = '0; reg_wdata = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cyc",   {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_ack",   {31'd0, reg_ack},   32'd0);
        check("rst_rdata", reg_rdata,          32'd0);
        check("rst_adr",   wbm_adr_o,          32'd0);
        check("rst_err",   {31'd0, bus_err},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: read, two wait states
        wb0 = wb_count; ack0 = ack_count;
        do_req(1'b0, 1'b1, 24'h00_1004, 4'hF, 32'h0, 2, 0, 32'hA5A5_0001, 0, lat, cyc_n);
        check("t1_adr", cap_adr, 32'h0000_1004);
        check("t1_we",  {31'd0, cap_we}, 32'd0);
        check("t1_lat", lat, 32'd4);
        check("t1_wb",  wb_count - wb0, 32'd1);
        check("t1_acks", ack_count - ack0, 32'd1);

        // 2: write, zero wait states
        wb0 = wb_count;
        do_req(1'b1, 1'b0, 24'h00_1008, 4'b0011, 32'h1234_5678, 0, 0, 32'hFFFF_FFFF, 0, lat, cyc_n);
        check("t2_sel", {28'd0, cap_sel}, 32'd3);
        check("t2_dat", cap_dat, 32'h1234_5678);
        check("t2_we",  {31'd0, cap_we}, 32'd1);
        check("t2_lat", lat, 32'd2);
        check("t2_wb",  wb_count - wb0, 32'd1);
        check("t2_rdata_hold", reg_rdata, 32'hA5A5_0001);
        check("idle_adr_hold", wbm_adr_o, 32'h0000_1008);
        check("idle_sel_hold", {28'd0, wbm_sel_o}, 32'd3);

        // 3: read terminated by wbm_err_i
        do_req(1'b0, 1'b1, 24'h00_2000, 4'hF, 32'h0, 1, 1, 32'h0, 0, lat, cyc_n);
        repeat (3) @(negedge clk);
        check("t3_sticky", {31'd0, bus_err}, 32'd1);
        clear_err();

        // 4: request held 10 cycles after reg_ack
        wb0 = wb_count; ack0 = ack_count;
        do_req(1'b0, 1'b1, 24'h00_3000, 4'hF, 32'h0, 1, 0, 32'h0000_0044, 10, lat, cyc_n);
        check("t4_wb",   wb_count - wb0, 32'd1);
        check("t4_acks", ack_count - ack0, 32'd1);
        do_req(1'b0, 1'b1, 24'h00_3004, 4'hF, 32'h0, 0, 0, 32'h0000_0055, 0, lat, cyc_n);
        check("t4_next_lat", lat, 32'd2);

        // simultaneous write+read: write wins, bus_err set
        do_req(1'b1, 1'b1, 24'h00_4000, 4'b1100, 32'hCAFE_0000, 0, 0, 32'h0, 0, lat, cyc_n);
        check("dbl_we", {31'd0, cap_we}, 32'd1);
        clear_err();

`ifdef QSPIS_WB_TMO_EN
        // 5: silent slave, timeout after 15 BUS cycles
        do_req(1'b0, 1'b1, 24'h00_5000, 4'hF, 32'h0, 0, 2, 32'h0, 0, lat, cyc_n);
        check("t5_cyc_cycles", cyc_n, 32'd15);
        check("t5_lat", lat, 32'd16);
        clear_err();
`endif

        // 6: reset asserted while the bus cycle is in flight
        sl_mode = 2;
        reg_rd = 1'b1; reg_addr = 24'h00_6000;
        repeat (3) @(negedge clk);
        check("t6_pre_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        ack0 = ack_count;
        #2 rst_n = 1'b0;
        #1;
        check("t6_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("t6_stb", {31'd0, wbm_stb_o}, 32'd0);
        check("t6_ack", {31'd0, reg_ack},   32'd0);
        reg_rd = 1'b0;
        last_rdata = '0;
        exp_bus_err = 1'b0;
        @(negedge clk);
        check("t6_rdata", reg_rdata, 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_ack", ack_count - ack0, 32'd0);
        do_req(1'b0, 1'b1, 24'h00_6004, 4'hF, 32'h0, 1, 0, 32'h0BAD_F00D, 0, lat, cyc_n);
        check("t6_lat", lat, 32'd3);
        check("t6_adr", cap_adr, 32'h0000_6004);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
